// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
// Bundles the request, inventory-load and result/coin-eject signals of the
// change dispenser.
//   master : the requester (drives start/amount and inventory loads,
//            observes busy/done/short/residue, coin pulses and inventories)
//   slave  : the dispenser itself
// Ports carried:
//   start, amount[AMT_W]          dispense request
//   load, load_sel[2], load_cnt   inventory add strobe (0=Q, 1=D, 2=N, 3=none)
//   busy, done, short, residue    status / completion
//   out_q, out_d, out_n           one-cycle coin eject pulses
//   inv_q, inv_d, inv_n           current inventory counts
// -----------------------------------------------------------------------------
interface change_dispenser_if #(
    parameter int AMT_W = 10,
    parameter int CNT_W = 8
);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             load;
    logic [1:0]       load_sel;
    logic [CNT_W-1:0] load_cnt;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] residue;
    logic             out_q;
    logic             out_d;
    logic             out_n;
    logic [CNT_W-1:0] inv_q;
    logic [CNT_W-1:0] inv_d;
    logic [CNT_W-1:0] inv_n;

    modport master (
        output start, amount, load, load_sel, load_cnt,
        input  busy, done, short, residue, out_q, out_d, out_n,
               inv_q, inv_d, inv_n
    );

    modport slave (
        input  start, amount, load, load_sel, load_cnt,
        output busy, done, short, residue, out_q, out_d, out_n,
               inv_q, inv_d, inv_n
    );
endinterface

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Pays out a requested amount greedily (largest affordable coin with stock
// first), one coin pulse at a time with GAP idle cycles after each pulse, and
// reports any unpaid remainder. Inventories are reloaded through a saturating
// add strobe that is accepted in any state.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-low reset
//   bus  : change_dispenser_if.slave (request, load, status, coin pulses,
//          inventory counts); every output is driven from a register
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int AMT_W = 10,
    parameter int CNT_W = 8,
    parameter int VAL_Q = 25,
    parameter int VAL_D = 10,
    parameter int VAL_N = 5,
    parameter int GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    change_dispenser_if.slave     bus
);
    // gap_r counts down from GAP-1 to 0
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [AMT_W-1:0] VQ_C = AMT_W'(VAL_Q);
    localparam logic [AMT_W-1:0] VD_C = AMT_W'(VAL_D);
    localparam logic [AMT_W-1:0] VN_C = AMT_W'(VAL_N);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_r;
    logic [AMT_W-1:0] rem_r;
    logic [AMT_W-1:0] residue_r;
    logic [AMT_W-1:0] sel_val_r;
    logic [1:0]       sel_r;
    logic [GW-1:0]    gap_r;
    logic [CNT_W-1:0] inv_q_r, inv_d_r, inv_n_r;
    logic             busy_r, done_r, short_r;
    logic             out_q_r, out_d_r, out_n_r;

    logic             pick_ok_s;
    logic [1:0]       pick_s;
    logic [AMT_W-1:0] pick_val_s;
    logic             dec_q_s, dec_d_s, dec_n_s;
    logic             add_q_s, add_d_s, add_n_s;

    // New inventory = min(inv - dec + add, 2^CNT_W-1); dec only when inv > 0.
    function automatic logic [CNT_W-1:0] next_inv(
        input logic [CNT_W-1:0] inv,
        input logic             dec,
        input logic             add_en,
        input logic [CNT_W-1:0] add
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, inv} - {{CNT_W{1'b0}}, dec}
            + (add_en ? {1'b0, add} : {(CNT_W+1){1'b0}});
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Greedy choice: largest coin not exceeding rem that is still in stock.
    always_comb begin
        pick_ok_s  = 1'b0;
        pick_s     = 2'd0;
        pick_val_s = {AMT_W{1'b0}};
        if (rem_r >= VQ_C && inv_q_r != {CNT_W{1'b0}}) begin
            pick_ok_s  = 1'b1;
            pick_s     = 2'd0;
            pick_val_s = VQ_C;
        end else if (rem_r >= VD_C && inv_d_r != {CNT_W{1'b0}}) begin
            pick_ok_s  = 1'b1;
            pick_s     = 2'd1;
            pick_val_s = VD_C;
        end else if (rem_r >= VN_C && inv_n_r != {CNT_W{1'b0}}) begin
            pick_ok_s  = 1'b1;
            pick_s     = 2'd2;
            pick_val_s = VN_C;
        end else begin
            pick_ok_s  = 1'b0;
        end
    end

    // Decrement/load strobes per coin; a PULSE-state decrement lands on the
    // same edge that raises the coin's eject pulse.
    always_comb begin
        dec_q_s = (state_r == S_PULSE) && (sel_r == 2'd0);
        dec_d_s = (state_r == S_PULSE) && (sel_r == 2'd1);
        dec_n_s = (state_r == S_PULSE) && (sel_r == 2'd2);
        add_q_s = bus.load && (bus.load_sel == 2'd0);
        add_d_s = bus.load && (bus.load_sel == 2'd1);
        add_n_s = bus.load && (bus.load_sel == 2'd2);
    end

    // Control FSM, inventories and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            rem_r     <= {AMT_W{1'b0}};
            residue_r <= {AMT_W{1'b0}};
            sel_val_r <= {AMT_W{1'b0}};
            sel_r     <= 2'd0;
            gap_r     <= {GW{1'b0}};
            inv_q_r   <= {CNT_W{1'b0}};
            inv_d_r   <= {CNT_W{1'b0}};
            inv_n_r   <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            short_r   <= 1'b0;
            out_q_r   <= 1'b0;
            out_d_r   <= 1'b0;
            out_n_r   <= 1'b0;
        end else begin
            inv_q_r <= next_inv(inv_q_r, dec_q_s, add_q_s, bus.load_cnt);
            inv_d_r <= next_inv(inv_d_r, dec_d_s, add_d_s, bus.load_cnt);
            inv_n_r <= next_inv(inv_n_r, dec_n_s, add_n_s, bus.load_cnt);
            out_q_r <= 1'b0;
            out_d_r <= 1'b0;
            out_n_r <= 1'b0;
            done_r  <= 1'b0;
            // busy follows the next state so it is high exactly outside IDLE
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        rem_r   <= bus.amount;
                        state_r <= S_SELECT;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                S_SELECT: begin
                    busy_r <= 1'b1;
                    if (pick_ok_s) begin
                        sel_r     <= pick_s;
                        sel_val_r <= pick_val_s;
                        state_r   <= S_PULSE;
                    end else begin
                        state_r   <= S_DONE;
                    end
                end
                S_PULSE: begin
                    busy_r  <= 1'b1;
                    out_q_r <= (sel_r == 2'd0);
                    out_d_r <= (sel_r == 2'd1);
                    out_n_r <= (sel_r == 2'd2);
                    rem_r   <= rem_r - sel_val_r;
                    if (GAP > 0) begin
                        gap_r   <= GW'(GAP - 1);
                        state_r <= S_GAP;
                    end else begin
                        state_r <= S_SELECT;
                    end
                end
                S_GAP: begin
                    busy_r <= 1'b1;
                    if (gap_r == {GW{1'b0}}) begin
                        state_r <= S_SELECT;
                    end else begin
                        gap_r   <= gap_r - {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    done_r    <= 1'b1;
                    short_r   <= (rem_r != {AMT_W{1'b0}});
                    residue_r <= rem_r;
                    busy_r    <= 1'b0;
                    state_r   <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.short   = short_r;
    assign bus.residue = residue_r;
    assign bus.out_q   = out_q_r;
    assign bus.out_d   = out_d_r;
    assign bus.out_n   = out_n_r;
    assign bus.inv_q   = inv_q_r;
    assign bus.inv_d   = inv_d_r;
    assign bus.inv_n   = inv_n_r;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Self-checking bench for change_dispenser (default parameters). A reference
// model keeps coin inventories as plain integers, pays amounts greedily and
// predicts coin order, pulse cycles (2 + k*(2+GAP)) and done cycle
// (2 + n*(2+GAP)) counted from the start edge.
// -----------------------------------------------------------------------------
module tb_change_dispenser;
    localparam int AMT_W = 10;
    localparam int CNT_W = 8;
    localparam int GAP   = 1;
    localparam int MAXC  = 255;
    localparam int VALS [3] = '{25, 10, 5};

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   inv_m [3];

    change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

    change_dispenser #(
        .AMT_W(AMT_W), .CNT_W(CNT_W),
        .VAL_Q(25), .VAL_D(10), .VAL_N(5), .GAP(GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inv(input string tag);
        check_val({tag, "_inv_q"}, int'(bus.inv_q), inv_m[0]);
        check_val({tag, "_inv_d"}, int'(bus.inv_d), inv_m[1]);
        check_val({tag, "_inv_n"}, int'(bus.inv_n), inv_m[2]);
    endtask

    task automatic model_load(input int sel, input int cnt);
        if (sel < 3) begin
            inv_m[sel] = (inv_m[sel] + cnt > MAXC) ? MAXC : inv_m[sel] + cnt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        inv_m = '{0, 0, 0};
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_done", int'(bus.done), 0);
        check_val("rst_short", int'(bus.short), 0);
        check_val("rst_residue", int'(bus.residue), 0);
        check_inv("rst");
        rst = 1'b1;
    endtask

    task automatic do_load(input int sel, input int cnt);
        @(negedge clk);
        bus.load     = 1'b1;
        bus.load_sel = 2'(sel);
        bus.load_cnt = CNT_W'(cnt);
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        model_load(sel, cnt);
        check_inv("load");
    endtask

    // One dispense transaction. Optional load alongside start, optional
    // stray start while busy (poke_cyc), optional load at mid_cyc.
    task automatic run_txn(input int amt, input bit ld_en, input int ld_sel,
                           input int ld_cnt, input int poke_cyc,
                           input int mid_cyc, input int mid_sel,
                           input int mid_cnt);
        int exp_coin[$];
        int got_coin[$];
        int got_cyc[$];
        int r, cyc, budget, done_cyc, multi, n, got_short, got_res, busy_end;
        bit got_done;
        // reference model
        if (ld_en) model_load(ld_sel, ld_cnt);
        r = amt;
        for (int guard = 0; guard < 1000; guard++) begin
            int c;
            c = -1;
            for (int k = 0; k < 3; k++) begin
                if (c < 0 && r >= VALS[k] && inv_m[k] > 0) c = k;
            end
            if (c < 0) break;
            exp_coin.push_back(c);
            r -= VALS[c];
            inv_m[c]--;
        end
        if (mid_cyc >= 0) model_load(mid_sel, mid_cnt);
        n = exp_coin.size();
        budget = 2 + (n + 1) * (2 + GAP) + 6;
        // drive
        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = AMT_W'(amt);
        if (ld_en) begin
            bus.load     = 1'b1;
            bus.load_sel = 2'(ld_sel);
            bus.load_cnt = CNT_W'(ld_cnt);
        end
        cyc = -1; got_done = 1'b0; done_cyc = -1; multi = 0;
        got_short = -1; got_res = -1; busy_end = -1;
        while (!got_done && cyc < budget) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (int'(bus.out_q) + int'(bus.out_d) + int'(bus.out_n) > 1) multi = 1;
            if (bus.out_q) begin got_coin.push_back(0); got_cyc.push_back(cyc); end
            if (bus.out_d) begin got_coin.push_back(1); got_cyc.push_back(cyc); end
            if (bus.out_n) begin got_coin.push_back(2); got_cyc.push_back(cyc); end
            if (cyc == 0) check_val("busy_after_start", int'(bus.busy), 1);
            if (bus.done) begin
                got_done  = 1'b1;
                done_cyc  = cyc;
                got_short = int'(bus.short);
                got_res   = int'(bus.residue);
                busy_end  = int'(bus.busy);
            end
            if (cyc == 0) begin
                bus.start = 1'b0;
                bus.load  = 1'b0;
            end
            if (cyc == poke_cyc) begin
                bus.start  = 1'b1;
                bus.amount = AMT_W'(amt + 37);
            end else if (cyc == poke_cyc + 1) begin
                bus.start  = 1'b0;
            end
            if (cyc == mid_cyc) begin
                bus.load     = 1'b1;
                bus.load_sel = 2'(mid_sel);
                bus.load_cnt = CNT_W'(mid_cnt);
            end else if (cyc == mid_cyc + 1) begin
                bus.load = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.load  = 1'b0;
        check_val("done_seen", int'(got_done), 1);
        check_val("done_cycle", done_cyc, 2 + n * (2 + GAP));
        check_val("pulse_count", got_coin.size(), n);
        for (int i = 0; i < n && i < got_coin.size(); i++) begin
            check_val("coin_kind", got_coin[i], exp_coin[i]);
            check_val("coin_cycle", got_cyc[i], 2 + i * (2 + GAP));
        end
        check_val("one_hot_pulse", multi, 0);
        check_val("short", got_short, (r != 0) ? 1 : 0);
        check_val("residue", got_res, r);
        check_val("busy_at_done", busy_end, 0);
        check_inv("txn");
    endtask

    // Reset asserted while a coin pulse is pending: outputs clear, no done.
    task automatic abort_test();
        int saw_done;
        saw_done = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.amount = AMT_W'(50);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        inv_m = '{0, 0, 0};
        check_val("abort_out_q", int'(bus.out_q), 0);
        check_val("abort_out_dn", int'(bus.out_d) + int'(bus.out_n), 0);
        check_val("abort_busy", int'(bus.busy), 0);
        check_val("abort_done", int'(bus.done), 0);
        check_inv("abort");
        rst = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) saw_done = 1;
        end
        check_val("abort_no_done", saw_done, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        inv_m = '{0, 0, 0};
        rst = 1'b0;
        bus.start = 1'b0; bus.amount = '0;
        bus.load = 1'b0; bus.load_sel = 2'd0; bus.load_cnt = '0;
        repeat (3) @(posedge clk);
        do_reset();

        // 4/4/4 inventory, 40 -> Q, D, N with done at cycle 11
        do_load(0, 4); do_load(1, 4); do_load(2, 4);
        run_txn(40, 0, 0, 0, -1, -1, 0, 0);

        // amount 0 -> immediate done, no pulses
        run_txn(0, 0, 0, 0, -1, -1, 0, 0);

        // 0/1/1 inventory, 30 -> D, N, short, residue 15
        do_reset();
        do_load(1, 1); do_load(2, 1);
        run_txn(30, 0, 0, 0, -1, -1, 0, 0);

        // Full inventory, 43
        do_load(0, 255); do_load(1, 255); do_load(2, 255);
        run_txn(43, 0, 0, 0, -1, -1, 0, 0);
        // saturation on N and an ignored load_sel=3
        do_load(2, 10);
        do_load(3, 7);

        // Exhausted Q falls through: 25 -> D, D, N
        do_reset();
        do_load(1, 5); do_load(2, 5);
        run_txn(25, 0, 0, 0, 2, -1, 0, 0);

        // N load coinciding with the N pulse: 5 - 1 + 1
        do_reset();
        do_load(2, 5);
        run_txn(5, 0, 0, 0, -1, 1, 2, 1);

        // start and load in the same IDLE cycle
        do_reset();
        run_txn(35, 1, 0, 2, -1, -1, 0, 0);

        // start while busy is ignored
        do_load(1, 9);
        run_txn(60, 0, 0, 0, 3, -1, 0, 0);

        // reset during a pulse
        do_load(0, 3);
        abort_test();

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            int nl;
            nl = $urandom_range(0, 2);
            for (int l = 0; l < nl; l++) begin
                do_load($urandom_range(0, 3),
                        ($urandom_range(0, 9) == 0) ? 250 : $urandom_range(0, 6));
            end
            if ($urandom_range(0, 3) == 0) begin
                run_txn($urandom_range(0, 150), 1, $urandom_range(0, 3),
                        $urandom_range(0, 5), -1, -1, 0, 0);
            end else begin
                run_txn($urandom_range(0, 150), 0, 0, 0,
                        ($urandom_range(0, 1) == 1) ? 2 : -1, -1, 0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
